// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared opcodes, state/class enums and datapath select encodings for mc_ctrl
// Optional feature macro: MC_CTRL_TRAP_EN adds the TRAP state.
package mc_ctrl_pkg;
  localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_OP_IMM = 7'b0010011, OPC_AUIPC = 7'b0010111,
                         OPC_STORE = 7'b0100011, OPC_OP = 7'b0110011, OPC_LUI = 7'b0110111,
                         OPC_BRANCH = 7'b1100011, OPC_JALR = 7'b1100111, OPC_JAL = 7'b1101111;
`ifdef MC_CTRL_TRAP_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
`endif
  typedef enum logic [3:0] {
    CLS_ILL, CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR
  } cls_t;
  localparam logic [2:0] SRCB_REG = 3'd0, SRCB_IMMI = 3'd1, SRCB_IMMU = 3'd2,
                         SRCB_IMMS = 3'd3, SRCB_IMMB = 3'd4, SRCB_IMMJ = 3'd5;
  localparam logic [2:0] DEST_ALU = 3'd0, DEST_SHIFT = 3'd1, DEST_IMMU = 3'd2, DEST_MEM = 3'd3, DEST_PC4 = 3'd4;
  localparam logic PC_SEL_PC4 = 1'b0, PC_SEL_ALU = 1'b1;
  localparam logic ADDR_PC = 1'b0, ADDR_ALU = 1'b1;
  localparam logic SRCA_PC = 1'b0, SRCA_RS1 = 1'b1;
  localparam logic [2:0] ALUOP_ADD = 3'b000;
  function automatic logic is_shift(input logic [2:0] f3);
    return f3 == 3'b001 || f3 == 3'b101;
  endfunction
endpackage

// File: rtl/mc_ctrl_op_dec.sv
// mc_ctrl_op_dec: combinational RV32I opcode-to-class decoder with illegal flag
// Ports: opcode (IR[6:0]) in; cls (instruction class), illegal (unsupported opcode) out.
module mc_ctrl_op_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic       illegal
);
  always_comb begin
    case (opcode)
      OPC_OP:     cls = CLS_OP;
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      default:    cls = CLS_ILL;
    endcase
  end
  assign illegal = cls == CLS_ILL;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control FSM (fetch/decode/exec/mem/wb) over a req/ready memory port
// Inputs: clk, reset (async, active-high), opcode/funct3 from IR, br_taken, mem_ready.
// Outputs: datapath selects (pc_sel, addr_sel, src_a_sel, src_b_sel, alu_set/alu_op, shamt_sel,
//   dest_sel, recode), strobes (ir_write, pc_write, reg_write, mem_req, mem_we), timeout_err, trap.
// Optional macro MC_CTRL_TRAP_EN: illegal opcode or memory timeout parks the FSM in TRAP.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       src_a_sel,
  output logic [2:0] src_b_sel,
  output logic       alu_set,
  output logic [2:0] alu_op,
  output logic       shamt_sel,
  output logic [2:0] dest_sel,
  output logic       reg_write,
  output logic       recode,
  output logic       timeout_err,
  output logic       trap
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);
`ifdef MC_CTRL_TRAP_EN
  localparam state_t TMO_NEXT = S_TRAP;
  localparam state_t ILL_NEXT = S_TRAP;
`else
  localparam state_t TMO_NEXT = S_FETCH;
  localparam state_t ILL_NEXT = S_EXEC;
`endif
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cls_t             cls;
  logic             illegal, waiting, tmo;

  mc_ctrl_op_dec u_op_dec (.opcode(opcode), .cls(cls), .illegal(illegal));

  assign waiting = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
  // The cycle in which the counter already holds MEM_TIMEOUT and ready is still low is the give-up cycle.
  assign tmo = waiting && MEM_TIMEOUT != 0 && cnt_q == TMO;

  always_comb begin
    state_d = state_q;
    cnt_d = (waiting && !tmo) ? cnt_q + 1'b1 : '0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_sel = PC_SEL_PC4;
    mem_req = 1'b0;
    mem_we = 1'b0;
    addr_sel = ADDR_PC;
    src_a_sel = SRCA_PC;
    src_b_sel = SRCB_REG;
    alu_set = 1'b0;
    alu_op = ALUOP_ADD;
    shamt_sel = 1'b0;
    dest_sel = DEST_ALU;
    reg_write = 1'b0;
    recode = 1'b0;
    timeout_err = 1'b0;
    trap = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_write = mem_ready;
        timeout_err = tmo;
        state_d = mem_ready ? S_DECODE : tmo ? TMO_NEXT : S_FETCH;
      end
      S_DECODE: state_d = illegal ? ILL_NEXT : S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (cls)
          CLS_OP, CLS_OP_IMM: begin
            src_a_sel = SRCA_RS1;
            src_b_sel = (cls == CLS_OP) ? SRCB_REG : SRCB_IMMI;
            dest_sel = is_shift(funct3) ? DEST_SHIFT : DEST_ALU;
            shamt_sel = cls == CLS_OP_IMM && is_shift(funct3);
            recode = cls == CLS_OP;
            reg_write = 1'b1;
            pc_write = 1'b1;
          end
          CLS_LUI: begin
            dest_sel = DEST_IMMU;
            reg_write = 1'b1;
            pc_write = 1'b1;
          end
          CLS_AUIPC: begin
            src_b_sel = SRCB_IMMU;
            alu_set = 1'b1;
            reg_write = 1'b1;
            pc_write = 1'b1;
          end
          CLS_LOAD, CLS_STORE: begin
            src_a_sel = SRCA_RS1;
            src_b_sel = (cls == CLS_LOAD) ? SRCB_IMMI : SRCB_IMMS;
            alu_set = 1'b1;
            state_d = S_MEM;
          end
          CLS_BRANCH: begin
            src_b_sel = SRCB_IMMB;
            alu_set = 1'b1;
            pc_write = 1'b1;
            pc_sel = br_taken;
          end
          CLS_JAL, CLS_JALR: begin
            src_a_sel = (cls == CLS_JALR) ? SRCA_RS1 : SRCA_PC;
            src_b_sel = (cls == CLS_JALR) ? SRCB_IMMI : SRCB_IMMJ;
            alu_set = 1'b1;
            dest_sel = DEST_PC4;
            reg_write = 1'b1;
            pc_write = 1'b1;
            pc_sel = PC_SEL_ALU;
          end
          default: pc_write = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        addr_sel = ADDR_ALU;
        mem_we = cls == CLS_STORE;
        pc_write = mem_ready && cls == CLS_STORE;
        timeout_err = tmo;
        state_d = mem_ready ? ((cls == CLS_LOAD) ? S_WB : S_FETCH) : tmo ? TMO_NEXT : S_MEM;
      end
      S_WB: begin
        dest_sel = DEST_MEM;
        reg_write = 1'b1;
        pc_write = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MC_CTRL_TRAP_EN
      S_TRAP: trap = 1'b1;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for mc_ctrl with MEM_TIMEOUT=4
module tb_mc_ctrl;
  localparam logic [6:0] LOAD = 7'b0000011, OPI = 7'b0010011, AUIPC = 7'b0010111, STORE = 7'b0100011,
                         OP = 7'b0110011, LUI = 7'b0110111, BR = 7'b1100011, JALR = 7'b1100111;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic br_taken = 1'b0, mem_ready = 1'b0;
  logic ir_write, pc_write, pc_sel, mem_req, mem_we, addr_sel, src_a_sel, alu_set, shamt_sel;
  logic reg_write, recode, timeout_err, trap;
  logic [2:0] src_b_sel, alu_op, dest_sel;
  logic [21:0] outs;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .src_a_sel(src_a_sel),
    .src_b_sel(src_b_sel), .alu_set(alu_set), .alu_op(alu_op), .shamt_sel(shamt_sel),
    .dest_sel(dest_sel), .reg_write(reg_write), .recode(recode), .timeout_err(timeout_err),
    .trap(trap)
  );

  assign outs = {ir_write, pc_write, pc_sel, mem_req, mem_we, addr_sel, src_a_sel, src_b_sel, alu_set,
                 alu_op, shamt_sel, dest_sel, reg_write, recode, timeout_err, trap};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic rdy, input logic br);
    @(negedge clk);
    mem_ready = rdy;
    br_taken = br;
    #1;
  endtask

  task automatic fd(input logic [6:0] op, input logic [2:0] f3);
    go(1'b1, 1'b0);
    opcode = op;
    funct3 = f3;
    chk("fetch_req", 32'(mem_req), 1);
    chk("fetch_irw", 32'(ir_write), 1);
    chk("fetch_addr", 32'({addr_sel, mem_we}), 0);
    go(1'b1, 1'b0);
    chk("decode_quiet", 32'(outs), 0);
  endtask

  task automatic rst_seq();
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_outs", 32'(outs), 0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1 chk("rst_idle", 32'(outs), 0);
  endtask

  initial begin
    int reqs;
    repeat (2) @(negedge clk);
    #1 chk("reset_outs", 32'(outs), 0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1 chk("idle_outs", 32'(outs), 0);
    fd(OPI, 3'b000);
    go(1'b1, 1'b0);
    chk("addi_wr", 32'({reg_write, pc_write, pc_sel}), 32'b110);
    chk("addi_sel", 32'({src_a_sel, src_b_sel, dest_sel, alu_set, recode}), 32'b1_001_000_0_0);
    fd(LOAD, 3'b010);
    go(1'b1, 1'b0);
    chk("lw_exec", 32'({src_a_sel, src_b_sel, alu_set, reg_write, pc_write, mem_req}), 32'b1_001_1_0_0_0);
    reqs = 0;
    for (int i = 0; i < 3; i++) begin
      go(i == 2, 1'b0);
      reqs += int'(mem_req);
      chk("lw_mem", 32'({addr_sel, mem_we, reg_write, pc_write}), 32'b1000);
    end
    chk("lw_req_cycles", 32'(reqs), 3);
    go(1'b1, 1'b0);
    chk("lw_wb", 32'({dest_sel, reg_write, pc_write, pc_sel, mem_req}), 32'b011_1_1_0_0);
    fd(BR, 3'b000);
    go(1'b1, 1'b1);
    chk("beq_t", 32'({pc_write, pc_sel, reg_write, src_a_sel, src_b_sel, alu_set}), 32'b1_1_0_0_100_1);
    fd(BR, 3'b000);
    go(1'b1, 1'b0);
    chk("beq_nt", 32'({pc_write, pc_sel, reg_write}), 32'b100);
    fd(JALR, 3'b000);
    go(1'b1, 1'b0);
    chk("jalr", 32'({src_a_sel, src_b_sel, dest_sel, reg_write, pc_write, pc_sel}), 32'b1_001_100_1_1_1);
    fd(OPI, 3'b101);
    go(1'b1, 1'b0);
    chk("srai", 32'({dest_sel, shamt_sel, recode, src_b_sel}), 32'b001_1_0_001);
    fd(OP, 3'b101);
    go(1'b1, 1'b0);
    chk("sra", 32'({dest_sel, shamt_sel, recode, src_b_sel, reg_write}), 32'b001_0_1_000_1);
    fd(LUI, 3'b000);
    go(1'b1, 1'b0);
    chk("lui", 32'({dest_sel, reg_write, pc_write, alu_set}), 32'b010_1_1_0);
    fd(AUIPC, 3'b000);
    go(1'b1, 1'b0);
    chk("auipc", 32'({src_a_sel, src_b_sel, alu_set, alu_op, dest_sel, reg_write}), 32'b0_010_1_000_000_1);
    opcode = OPI;
    for (int i = 0; i < 4; i++) begin
      go(1'b0, 1'b0);
      chk("late_wait", 32'({mem_req, ir_write, timeout_err}), 32'b100);
    end
    go(1'b1, 1'b0);
    chk("late_accept", 32'({mem_req, ir_write, timeout_err}), 32'b110);
    go(1'b1, 1'b0);
    chk("late_decode", 32'(outs), 0);
    go(1'b1, 1'b0);
    chk("late_exec", 32'({reg_write, pc_write}), 32'b11);
    for (int i = 0; i < 4; i++) begin
      go(1'b0, 1'b0);
      chk("tmo_wait", 32'({mem_req, timeout_err}), 32'b10);
    end
    go(1'b0, 1'b0);
    chk("tmo_pulse", 32'({timeout_err, ir_write}), 32'b10);
    go(1'b1, 1'b0);
`ifdef MC_CTRL_TRAP_EN
    chk("tmo_trap", 32'({trap, mem_req, ir_write, timeout_err}), 32'b1000);
`else
    chk("tmo_refetch", 32'({trap, mem_req, ir_write, timeout_err}), 32'b0110);
`endif
    rst_seq();
    fd(7'h00, 3'b000);
    go(1'b1, 1'b0);
`ifdef MC_CTRL_TRAP_EN
    chk("ill_trap", 32'(outs), 1);
`else
    chk("ill_nop", 32'({trap, pc_write, pc_sel, reg_write}), 32'b0100);
`endif
    rst_seq();
    fd(STORE, 3'b010);
    go(1'b1, 1'b0);
    chk("sw_exec", 32'({src_a_sel, src_b_sel, alu_set, mem_req}), 32'b1_011_1_0);
    go(1'b0, 1'b0);
    chk("sw_mem", 32'({mem_req, mem_we, addr_sel, pc_write}), 32'b1110);
    #2 reset = 1'b1;
    #1 chk("sw_reset_drop", 32'(outs), 0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1 chk("sw_reset_idle", 32'(outs), 0);
    go(1'b1, 1'b0);
    chk("sw_restart", 32'({mem_req, mem_we, addr_sel, pc_write}), 32'b1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
